can_destuffer: RTL

- Bit-stream destuffer that sits directly upstream of the frame storage shift register.
- Takes the sampled CAN bus bit at each sample-point strobe and tracks runs of equal bits.
- Flags and removes stuff bits, and reports stuff errors.
- Handles bus-idle / start-of-frame detection, so the downstream store receives only data bits plus a stuff flag.

---
 rtl/can_destuffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/can_destuffer.sv
// CAN bit destuffer: bus-idle/SOF detection, stuff-bit removal and stuff-error reporting.
// Optional macro CAN_DESTUFF_STUFF_CNT_EN enables the per-frame stuff-bit counter on stuff_cnt.
module can_destuffer #(
    parameter int STUFF_LEN = 5,
    parameter int IDLE_BITS = 11,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sp,
    input  logic             CAN_RX,
    input  logic             stuff_en,
    input  logic             frame_done,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             isStuff,
    output logic             stuff_err,
    output logic             sof,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             busy,
    output logic [7:0]       stuff_cnt
);
    localparam int RUN_W = $clog2(STUFF_LEN + 1);
    localparam int IDL_W = $clog2(IDLE_BITS + 1);

    typedef enum logic [1:0] {S_WAIT_IDLE, S_IDLE, S_ACTIVE, S_ERROR} state_t;

    state_t           r_state;
    logic [RUN_W-1:0] r_run;
    logic             r_last;
    logic [IDL_W-1:0] r_idle;
    logic             w_slot;
    logic             w_err;

    assign w_slot = stuff_en && (r_run == RUN_W'(STUFF_LEN));
    assign w_err  = sp && (r_state == S_ACTIVE) && w_slot && (CAN_RX == r_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_WAIT_IDLE;
            r_run     <= '0;
            r_last    <= 1'b1;
            r_idle    <= '0;
            bit_out   <= 1'b1;
            bit_valid <= 1'b0;
            isStuff   <= 1'b0;
            stuff_err <= 1'b0;
            sof       <= 1'b0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            isStuff   <= 1'b0;
            stuff_err <= 1'b0;
            sof       <= 1'b0;
            case (r_state)
                S_WAIT_IDLE: begin
                    if (sp) begin
                        bit_out <= CAN_RX;
                        if (!CAN_RX) begin
                            r_idle <= '0;
                        end else if (r_idle >= IDL_W'(IDLE_BITS - 1)) begin
                            r_idle  <= IDL_W'(IDLE_BITS);
                            r_state <= S_IDLE;
                        end else begin
                            r_idle <= r_idle + IDL_W'(1);
                        end
                    end
                end
                S_IDLE: begin
                    if (sp) begin
                        bit_out <= CAN_RX;
                        if (!CAN_RX) begin
                            r_state   <= S_ACTIVE;
                            sof       <= 1'b1;
                            bit_valid <= 1'b1;
                            bit_cnt   <= CNT_W'(1);
                            r_run     <= RUN_W'(1);
                            r_last    <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (sp) begin
                        bit_out <= CAN_RX;
                        if (w_slot) begin
                            // Bit after STUFF_LEN equal bits must be the complement.
                            if (CAN_RX != r_last) begin
                                isStuff <= 1'b1;
                                r_run   <= RUN_W'(1);
                                r_last  <= CAN_RX;
                            end else begin
                                stuff_err <= 1'b1;
                                r_state   <= S_ERROR;
                            end
                        end else begin
                            bit_valid <= 1'b1;
                            if (bit_cnt != '1)
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            if (CAN_RX == r_last) begin
                                if (r_run != RUN_W'(STUFF_LEN))
                                    r_run <= r_run + RUN_W'(1);
                            end else begin
                                r_run <= RUN_W'(1);
                            end
                            r_last <= CAN_RX;
                        end
                    end
                    // A coincident sp bit is still emitted above; the frame then closes.
                    if (frame_done && !w_err) begin
                        r_state <= S_WAIT_IDLE;
                        bit_cnt <= '0;
                        r_idle  <= '0;
                        busy    <= 1'b0;
                    end
                end
                S_ERROR: begin
                    r_state <= S_WAIT_IDLE;
                    bit_cnt <= '0;
                    r_run   <= '0;
                    r_last  <= 1'b1;
                    r_idle  <= '0;
                    busy    <= 1'b0;
                end
                default: r_state <= S_WAIT_IDLE;
            endcase
        end
    end

`ifdef CAN_DESTUFF_STUFF_CNT_EN
    logic [7:0] r_stuff_cnt;
    logic       w_stuff;
    logic       w_sof;

    assign w_stuff = sp && (r_state == S_ACTIVE) && w_slot && (CAN_RX != r_last);
    assign w_sof   = sp && (r_state == S_IDLE) && !CAN_RX;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stuff_cnt <= '0;
        else if (w_sof)
            r_stuff_cnt <= '0;
        else if (w_stuff && (r_stuff_cnt != 8'hFF))
            r_stuff_cnt <= r_stuff_cnt + 8'd1;
    end

    assign stuff_cnt = r_stuff_cnt;
`else
    assign stuff_cnt = 8'd0;
`endif
endmodule
